fnd_scan_driver: RTL
====================

Name: fnd_scan_driver

Overview:
Four-digit multiplexed 7-segment (FND) display driver. It consumes a 16-bit hex/BCD value, runs its own slot prescaler and digit-index counter, and drives active-low common and segment lines. An inter-digit blanking window suppresses ghosting. A double-buffered value register prevents tearing mid-frame, and a display on/off control is included.

Parameters:
P_CLK_DIV, 100000, i_clk cycles per digit slot; legal range >= 2.
P_BLANK, 1000, cycles at the start of each slot during which all commons are off; legal range 0 <= P_BLANK < P_CLK_DIV.

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous reset, active-high
i_value  input  16  display value; nibble k drives digit k (digit 0 = [3:0])
i_dp  input  4  decimal point per digit, 1 = lit
i_load  input  1  one-cycle strobe; captures i_value/i_dp into the pending buffer
i_on  input  1  1 = display enabled, 0 = dark
o_com  output  4  digit commons, active-low, one-hot-low when lit
o_seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
o_digit  output  2  current digit index (slot counter)

Behaviour:
- Reset (async, i_reset=1): o_com=4'b1111, o_seg=8'hFF, o_digit=0, prescaler=0, active/pending value=0, active/pending dp=0, pending_valid=0.
- Prescaler counts 0..P_CLK_DIV-1 while i_on=1. On the terminal count it wraps to 0 and the digit index increments mod 4 (3->0 wraps).
- Frame boundary = the cycle where prescaler is at terminal count and index=3.
- Load handling: on i_load=1, pending<=i_value/i_dp and pending_valid<=1.
- At a frame boundary, if pending_valid=1, then active<=pending and pending_valid<=0.
- If i_load=1 coincides with a frame boundary, active<=i_value/i_dp directly and pending_valid stays 0.
- Multiple loads within one frame: the last load wins.
- Output timing: o_com, o_seg and o_digit are registered. The value visible after clock edge N reflects the prescaler, index and active buffer as they stood before edge N, giving one cycle of latency.
- Blanking: when prescaler < P_BLANK, o_com=4'b1111. Otherwise o_com[index]=0 and all other bits are 1.
- o_seg carries the active-low hex decode of the active nibble for the current index, with bit7 = ~dp[index]. o_seg is driven during blanking as well; only o_com blanks.
- Hex decode, bits [6:0], 0..F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
- Off (i_on=0): next edge gives o_com=4'b1111 and o_seg=8'hFF, and prescaler and index clear to 0. Load capture and pending transfer continue; with the counters held, the transfer happens on the next frame boundary after re-enable. When i_on returns to 1, scanning restarts at digit 0 with a full blank window.
- Reset mid-scan: everything returns to reset values immediately. The pending load is discarded.
- Arithmetic: prescaler width is clog2(P_CLK_DIV), computed from the parameter. Counters never exceed their terminal values.

Test Plan:
1. Reset and load: P_CLK_DIV=8, P_BLANK=2; assert reset, release; i_on=1; i_load with i_value=16'h1234, i_dp=4'b0001.
   - While reset is asserted: o_com=1111, o_seg=FF.
   - After the first frame boundary, digit 0 slot: o_com=1110 and o_seg=8'h19 (digit 4 code 99 with dp lit).
   - Digit 3 slot: o_seg=F9.
2. Blanking window: in each slot, o_com=1111 for exactly 2 cycles, then one-hot-low for 6 cycles. o_digit steps 0,1,2,3,0 every 8 cycles.
3. Tear-free update: load 16'hABCD mid-frame (index=1). Digits 1..3 still show the old value; the change appears only from the next digit 0 slot (digit 0 o_seg=A1). Also pulse i_load exactly on the frame-boundary cycle and check the new value appears in the very next digit 0 slot.
4. On/off: drop i_on at index=2, prescaler=5.
   - Next edge: o_com=1111, o_seg=FF, o_digit=0.
   - After re-enable: 2 blank cycles, then digit 0 lit.
   - A load issued while i_on=0 is shown in the first frame after re-enable.
5. Async reset mid-operation: assert i_reset between clock edges. Outputs go to reset values without waiting for a clock edge, and any pending load is discarded.
6. Edge parameters: with P_BLANK=0, o_com is never 1111 while i_on=1. With P_CLK_DIV=2, the index advances every 2 cycles.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: four-digit multiplexed 7-segment scanner with blanking and a double-buffered value
module fnd_scan_driver #(
    parameter int P_CLK_DIV = 100000,
    parameter int P_BLANK   = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_load,
    input  logic        i_on,
    output logic [3:0]  o_com,
    output logic [7:0]  o_seg,
    output logic [1:0]  o_digit
);
    localparam int W = $clog2(P_CLK_DIV);
    localparam logic [W-1:0] C_TC = W'(P_CLK_DIV - 1);
    // active-low {g..a} patterns, entry 15 first
    localparam logic [15:0][6:0] C_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    logic [W-1:0]       r_pre;
    logic [1:0]         r_idx;
    logic [15:0]        r_act_val;
    logic [15:0]        r_pend_val;
    logic [3:0]         r_act_dp;
    logic [3:0]         r_pend_dp;
    logic               r_pend_vld;
    logic               w_tc;
    logic               w_frame;
    logic               w_blank;
    logic signed [31:0] w_pre_s;
    logic [3:0]         w_nib;

    assign w_tc    = r_pre == C_TC;
    assign w_frame = w_tc && (r_idx == 2'd3);
    // signed compare keeps P_BLANK = 0 a plain never-blank case
    assign w_pre_s = 32'(r_pre);
    assign w_blank = w_pre_s < P_BLANK;
    assign w_nib   = r_act_val[{r_idx, 2'b00} +: 4];

    // slot prescaler and digit index; both held at zero while the display is off
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (!i_on) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_tc) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // pending/active buffers: swap only at a frame boundary so a frame never tears
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_act_val  <= '0;
            r_act_dp   <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
        end else if (i_load && w_frame) begin
            r_act_val  <= i_value;
            r_act_dp   <= i_dp;
            r_pend_vld <= 1'b0;
        end else if (i_load) begin
            r_pend_val <= i_value;
            r_pend_dp  <= i_dp;
            r_pend_vld <= 1'b1;
        end else if (w_frame && r_pend_vld) begin
            r_act_val  <= r_pend_val;
            r_act_dp   <= r_pend_dp;
            r_pend_vld <= 1'b0;
        end
    end

    // registered drive: commons blank at slot start, segments always follow the current digit
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_com   <= 4'hF;
            o_seg   <= 8'hFF;
            o_digit <= 2'd0;
        end else begin
            o_com   <= (i_on && !w_blank) ? ~(4'b0001 << r_idx) : 4'hF;
            o_seg   <= i_on ? {~r_act_dp[r_idx], C_HEX[w_nib]} : 8'hFF;
            o_digit <= i_on ? r_idx : 2'd0;
        end
    end
endmodule
